// File: rtl/qtz_level_seg_buffer_if.sv
// Fetch-side and bind-side handshake bundle for the level segment buffer.
// Pure wiring, no latency.
// The producer sees in_ready; the consumer drives out_ready.
interface qtz_level_seg_buffer_if #(
  parameter int SEG_W           = 2000,
  parameter int FETCH_LANES     = 64,
  parameter int FEATURES_PER_CC = 59,
  parameter int SEG_IDX_W       = 3
);
  logic                                    in_valid;
  logic                                    in_ready;
  logic [FETCH_LANES-1:0][SEG_W-1:0]       im_fetch_outputs;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [FEATURES_PER_CC-1:0][SEG_W-1:0]   level_hvs;
  logic [SEG_IDX_W-1:0]                    out_seg_idx;
  logic                                    out_last;
  logic                                    hv_done;

  // Fetch stage / bind stage side (testbench or surrounding pipeline)
  modport master (
    output in_valid, im_fetch_outputs, out_ready,
    input  in_ready, out_valid, level_hvs, out_seg_idx, out_last, hv_done
  );

  // Buffer side
  modport slave (
    input  in_valid, im_fetch_outputs, out_ready,
    output in_ready, out_valid, level_hvs, out_seg_idx, out_last, hv_done
  );
endinterface

// File: rtl/qtz_level_seg_buffer.sv
// Captures a lane window of IM fetch beats as tagged HV segments in a 2-entry FIFO.
// Latency: 1 cycle from accepted beat to head when empty; hv_done 1 cycle after last-seg pop.
// Backpressure: in_ready depends only on registered occupancy; a full FIFO refuses beats even when popping.
module qtz_level_seg_buffer #(
  parameter int HV_DIM          = 10000,
  parameter int NUM_SEGMENTS    = 5,
  parameter int FETCH_LANES     = 64,
  parameter int FEATURES_PER_CC = 59,
  parameter int LANE_OFFSET     = 0,
  parameter int SEG_IDX_W       = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    seg_restart,
  qtz_level_seg_buffer_if.slave   bus
);
  // HV_DIM must divide evenly; LANE_OFFSET+FEATURES_PER_CC must fit in FETCH_LANES.
  localparam int SEG_W = HV_DIM / NUM_SEGMENTS;
  localparam logic [SEG_IDX_W-1:0] LAST_SEG = SEG_IDX_W'(NUM_SEGMENTS - 1);

  typedef logic [FEATURES_PER_CC-1:0][SEG_W-1:0] seg_data_t;
  typedef struct packed {
    seg_data_t            dat;
    logic [SEG_IDX_W-1:0] idx;
    logic                 last;
  } entry_t;

  entry_t               mem [2];
  entry_t               head_q;
  entry_t               new_entry;
  logic [1:0]           count;
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [SEG_IDX_W-1:0] seg_cnt;
  logic                 hv_done_q;
  logic                 in_ready;
  logic                 push;
  logic                 pop;

  // Readiness comes from registered occupancy only, so out_ready never reaches in_ready.
  assign in_ready = nrst && !seg_restart && (count < 2'd2);
  assign push     = bus.in_valid && in_ready;
  // A pop during restart/reset is voided by the clear branch below.
  assign pop      = (count != 2'd0) && bus.out_ready;

  assign new_entry.dat  = bus.im_fetch_outputs[LANE_OFFSET +: FEATURES_PER_CC];
  assign new_entry.idx  = seg_cnt;
  assign new_entry.last = (seg_cnt == LAST_SEG);

  // Storage write; push is already held off during reset and restart.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // Occupancy, pointers, segment counter and the registered head copy.
  always_ff @(posedge clk) begin
    if (!nrst || seg_restart) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      seg_cnt   <= '0;
      head_q    <= '0;
      hv_done_q <= 1'b0;
    end else begin
      hv_done_q <= pop && head_q.last;
      if (push) begin
        wr_ptr  <= ~wr_ptr;
        seg_cnt <= (seg_cnt == LAST_SEG) ? '0 : seg_cnt + SEG_IDX_W'(1);
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
      // Head moves to the second entry, or to the incoming beat when it becomes the only one;
      // otherwise it holds, which also gives the idle hold of the last head value.
      if (pop && (count == 2'd2)) begin
        head_q <= mem[~rd_ptr];
      end else if (push && ((count == 2'd0) || pop)) begin
        head_q <= new_entry;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = (count != 2'd0);
  assign bus.level_hvs   = head_q.dat;
  assign bus.out_seg_idx = head_q.idx;
  assign bus.out_last    = head_q.last;
  assign bus.hv_done     = hv_done_q;
endmodule

// File: tb/tb_qtz_level_seg_buffer.sv
// Bench for qtz_level_seg_buffer: directed scenarios plus random traffic vs. a queue model.
// Model advances at posedge, DUT compared at every negedge after the first reset edge.
// Inputs are driven at negedges.
module tb_qtz_level_seg_buffer;
  localparam int HV_DIM = 80;
  localparam int NSEG   = 5;
  localparam int SEG_W  = HV_DIM / NSEG;
  localparam int FL     = 64;
  localparam int FPC    = 59;
  localparam int OFF    = 5;
  localparam int SIW    = 3;

  typedef logic [FPC-1:0][SEG_W-1:0] data_t;
  typedef struct {
    data_t d;
    int    idx;
    bit    last;
  } ent_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic seg_restart = 1'b0;
  always #5 clk = ~clk;

  qtz_level_seg_buffer_if #(.SEG_W(SEG_W), .FETCH_LANES(FL), .FEATURES_PER_CC(FPC),
                            .SEG_IDX_W(SIW)) bus();

  qtz_level_seg_buffer #(.HV_DIM(HV_DIM), .NUM_SEGMENTS(NSEG), .FETCH_LANES(FL),
                         .FEATURES_PER_CC(FPC), .LANE_OFFSET(OFF)) dut (
    .clk(clk), .nrst(nrst), .seg_restart(seg_restart), .bus(bus)
  );

  ent_t q[$];
  ent_t held;
  int   seg;
  bit   exp_done;
  bit   armed;
  int   tests;
  int   fails;
  int   done_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    q.delete();
    seg = 0;
    exp_done = 0;
    held.d = '0;
    held.idx = 0;
    held.last = 0;
  endtask

  // Reference: a plain queue of at most two entries, with the spec's push/pop rules.
  task automatic model_step();
    ent_t e;
    bit   do_pop;
    bit   do_push;
    if (!nrst || seg_restart) begin
      clear_model();
    end else begin
      do_pop  = (q.size() > 0) && bus.out_ready;
      do_push = bus.in_valid && (q.size() < 2);
      exp_done = do_pop && q[0].last;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        for (int i = 0; i < FPC; i++) e.d[i] = bus.im_fetch_outputs[i + OFF];
        e.idx = seg;
        e.last = (seg == NSEG - 1);
        q.push_back(e);
        seg = (seg + 1) % NSEG;
      end
      if (q.size() > 0) held = q[0];
    end
  endtask

  initial begin
    clear_model();
    forever begin
      @(posedge clk);
      if (bus.hv_done === 1'b1) done_cnt++;
      model_step();
      armed = 1;
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    int bad;
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("in_ready", 32'(bus.in_ready), 32'(nrst && !seg_restart && (q.size() < 2)));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        chk("out_seg_idx", 32'(bus.out_seg_idx), 32'(held.idx));
        chk("out_last", 32'(bus.out_last), 32'(held.last));
        chk("hv_done", 32'(bus.hv_done), 32'(exp_done));
        bad = 0;
        for (int i = FPC - 1; i >= 0; i--) if (bus.level_hvs[i] !== held.d[i]) bad = i;
        chk($sformatf("level_hvs[%0d]", bad), 32'(bus.level_hvs[bad]), 32'(held.d[bad]));
      end
    end
  end

  task automatic drive_pat(input int s);
    for (int k = 0; k < FL; k++) bus.im_fetch_outputs[k] = SEG_W'(k * 16'h0101 + s);
  endtask

  task automatic drive_rand();
    for (int k = 0; k < FL; k++) bus.im_fetch_outputs[k] = SEG_W'($urandom);
  endtask

  task automatic restart_pulse();
    @(negedge clk);
    bus.in_valid = 0;
    seg_restart = 1;
    @(negedge clk);
    seg_restart = 0;
  endtask

  initial begin
    int d0;
    bus.in_valid = 0;
    bus.out_ready = 0;
    bus.im_fetch_outputs = '0;
    tests = 0;
    fails = 0;
    done_cnt = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    nrst = 1;

    // Five-beat hypervector with free-flowing consumer
    bus.out_ready = 1;
    d0 = done_cnt;
    for (int s = 0; s < NSEG; s++) begin
      bus.in_valid = 1;
      drive_pat(s);
      @(negedge clk);
      chk("t1_valid", 32'(bus.out_valid), 32'd1);
      chk("t1_idx", 32'(bus.out_seg_idx), 32'(s));
      chk("t1_last", 32'(bus.out_last), 32'(s == 4));
      chk("t1_lane1", 32'(bus.level_hvs[1]), 32'(16'(6 * 16'h0101 + s)));
    end
    bus.in_valid = 0;
    repeat (4) @(negedge clk);
    chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Backpressure: three beats against a stalled consumer
    bus.out_ready = 0;
    bus.in_valid = 1;
    drive_pat(0);
    @(negedge clk);
    drive_pat(1);
    @(negedge clk);
    drive_pat(2);
    chk("t2_full_in_ready", 32'(bus.in_ready), 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t2_hold_idx", 32'(bus.out_seg_idx), 32'd0);
      chk("t2_hold_lane0", 32'(bus.level_hvs[0]), 32'(16'(5 * 16'h0101)));
    end
    bus.out_ready = 1;
    @(negedge clk);
    chk("t2_drain1", 32'(bus.out_seg_idx), 32'd1);
    @(negedge clk);
    chk("t2_drain2", 32'(bus.out_seg_idx), 32'd2);
    bus.in_valid = 0;
    @(negedge clk);

    // Restart drops the in-flight beat and rewinds the segment counter
    restart_pulse();
    for (int s = 0; s < 3; s++) begin
      bus.in_valid = 1;
      drive_pat(s);
      @(negedge clk);
    end
    seg_restart = 1;
    drive_pat(7);
    @(negedge clk);
    chk("t3_valid_after_restart", 32'(bus.out_valid), 32'd0);
    seg_restart = 0;
    drive_pat(9);
    @(negedge clk);
    chk("t3_first_idx", 32'(bus.out_seg_idx), 32'd0);
    chk("t3_first_lane0", 32'(bus.level_hvs[0]), 32'(16'(5 * 16'h0101 + 9)));
    bus.in_valid = 0;

    // Lane window: lane k carries k
    restart_pulse();
    bus.in_valid = 1;
    for (int k = 0; k < FL; k++) bus.im_fetch_outputs[k] = SEG_W'(k);
    @(negedge clk);
    bus.in_valid = 0;
    chk("lane_first", 32'(bus.level_hvs[0]), 32'd5);
    chk("lane_last", 32'(bus.level_hvs[58]), 32'd63);

    // Steady stream of twelve beats
    restart_pulse();
    d0 = done_cnt;
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 1;
      drive_rand();
      #1 chk("t5_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      chk("t5_idx", 32'(bus.out_seg_idx), 32'(i % 5));
    end
    bus.in_valid = 0;
    repeat (3) @(negedge clk);
    chk("t5_done_pulses", 32'(done_cnt - d0), 32'd2);

    // Reset while full
    bus.out_ready = 0;
    bus.in_valid = 1;
    drive_rand();
    @(negedge clk);
    drive_rand();
    @(negedge clk);
    bus.in_valid = 0;
    nrst = 0;
    @(negedge clk);
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_lane0", 32'(bus.level_hvs[0]), 32'd0);
    chk("t6_in_ready", 32'(bus.in_ready), 32'd0);
    nrst = 1;
    #1 chk("t6_in_ready_rel", 32'(bus.in_ready), 32'd1);

    // Random traffic, checked by the model every cycle
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      nrst = ($urandom_range(0, 199) != 0);
      seg_restart = ($urandom_range(0, 39) == 0);
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      drive_rand();
    end
    @(negedge clk);
    nrst = 1;
    seg_restart = 0;
    bus.in_valid = 0;
    bus.out_ready = 1;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
